// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module : mips_ctrl_pkg
// Brief  : State encoding, opcodes, select codes and control word for the
//          multicycle MIPS main controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp codes are shared with the downstream ALU-control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
// ============================================================================
// Module : mips_ctrl_outdec
// Brief  : Pure combinational state-to-control-word decoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.alusrcb = SRCB_FOUR;
        // IR and PC load only on the cycle memory actually returns the word
        o_ctrl.irwrite = i_mem_ready;
        o_ctrl.pcwrite = i_mem_ready;
      end
      S_DECODE: o_ctrl.alusrcb = SRCB_IMM_SH2;
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REG;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca     = 1'b1;
        o_ctrl.alusrcb     = SRCB_REG;
        o_ctrl.aluop       = ALUOP_SUB;
        o_ctrl.pcsource    = PCSRC_ALUOUT;
        o_ctrl.pcwritecond = 1'b1;
      end
      S_ADDIEXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: o_ctrl.regwrite = 1'b1;
      S_JUMP: begin
        o_ctrl.pcsource = PCSRC_JUMP;
        o_ctrl.pcwrite  = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// ============================================================================
// Module : mips_multicycle_control
// Brief  : Main control FSM for the multicycle MIPS datapath with
//          memory-ready stalling.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter logic MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_ready;
  logic   w_illegal;
  ctrl_t  w_ctrl;

  assign w_mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_LW)      w_next = S_MEMREAD;
        else if (Op == OP_SW) w_next = S_MEMWRITE;
        else                  w_next = S_FETCH;
      end
      S_MEMREAD:  w_next = w_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = w_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_RTYPEWB;
      S_ADDIEXEC: w_next = S_ADDIWB;
      // Writeback/branch/jump states and unreachable codes all return to fetch
      default:    w_next = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (w_mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign PCWrite     = rst_n & w_ctrl.pcwrite;
  assign PCWriteCond = rst_n & w_ctrl.pcwritecond;
  assign IorD        = rst_n & w_ctrl.iord;
  assign MemRead     = rst_n & w_ctrl.memread;
  assign MemWrite    = rst_n & w_ctrl.memwrite;
  assign IRWrite     = rst_n & w_ctrl.irwrite;
  assign MemtoReg    = rst_n & w_ctrl.memtoreg;
  assign RegDst      = rst_n & w_ctrl.regdst;
  assign RegWrite    = rst_n & w_ctrl.regwrite;
  assign ALUSrcA     = rst_n & w_ctrl.alusrca;
  assign ALUSrcB     = {2{rst_n}} & w_ctrl.alusrcb;
  assign ALUOp       = {2{rst_n}} & w_ctrl.aluop;
  assign PCSource    = {2{rst_n}} & w_ctrl.pcsource;
  assign IllegalOp   = rst_n & w_illegal;
  assign State       = r_state;

endmodule

`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU-control decoder and drives ALUOp; the decoder combines ALUOp with the funct field to select the ALU operation. It sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, j and addi. It stalls on a memory-ready handshake.

Parameters:
MEM_WAIT_EN, 1, 1 = FETCH/MEMREAD/MEMWRITE hold until MemReady=1; 0 = MemReady ignored (treated as 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
Op  in  6  opcode, IR[31:26]; sampled only in DECODE
MemReady  in  1  memory completes access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero (beq)
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
MemtoReg  out  1  1 = MDR to register file, 0 = ALUOut
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct (to ALU control)
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
IllegalOp  out  1  one-cycle flag, unsupported opcode in DECODE
State  out  4  current state, debug/verification

Behaviour:
- Reset: when rst_n=0 at a rising edge, the state becomes FETCH. While rst_n=0, every output is forced to 0 except State. A reset during any state, including a stalled memory access, aborts to FETCH with no writeback.
- States and encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RTYPEWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
  - Codes 12-15 are unreachable. If entered, they output all zeros and go to FETCH next cycle.
- Outputs decode from the state (Moore) unless marked Mealy. Any output not listed is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=MemReady (Mealy). Go to DECODE when MemReady=1, else hold.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
    - Next state by Op: 000000 to EXECUTE; 100011 or 101011 to MEMADR; 000100 to BRANCH; 001000 to ADDIEXEC; 000010 to JUMP.
    - Any other Op: go to FETCH with IllegalOp=1 for this cycle (Mealy).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Op=100011 goes to MEMREAD, Op=101011 goes to MEMWRITE. Op is held stable by the IR.
  - MEMREAD: MemRead=1, IorD=1. Go to MEMWB when MemReady=1, else hold.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
  - MEMWRITE: MemWrite=1, IorD=1. Go to FETCH when MemReady=1, else hold with MemWrite still asserted.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RTYPEWB.
  - RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1. Go to FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
  - JUMP: PCSource=10, PCWrite=1. Go to FETCH.
- Cycle counts with no stall: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each stalled memory cycle adds 1.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - RegWrite and PCWrite are never both 1.
  - ALUOp=10 only in EXECUTE.
- With MEM_WAIT_EN=0, every memory state lasts exactly one cycle.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - state localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), shared with ALU control
  - ALUSrcB and PCSource select codes
- Natural split: state register plus next-state logic in this module. Optional sub-module `mips_ctrl_outdec` is a pure combinational state-to-control-word decoder, reusable by the bench as a reference model.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles in MEMWRITE with MemReady=0, then release. Required: all strobes 0 while in reset, State=0 after; first cycle MemRead=1 and, with MemReady=1, IRWrite=PCWrite=1.
- R-type: Op=000000, MemReady=1. Required: State 0,1,6,7,0; ALUOp=10 only in state 6; RegWrite=1 with RegDst=1 in state 7.
- lw with stall: Op=100011, MemReady low for 2 cycles in MEMREAD. Required: State 0,1,2,3,3,3,4,0; MemRead=IorD=1 throughout state 3; RegWrite with MemtoReg=1 in state 4.
- sw: Op=101011. Required: State 0,1,2,5,0; MemWrite=1 only in state 5; RegWrite never 1.
- Branch and jump: Op=000100 gives State 0,1,8,0 with ALUOp=01, PCWriteCond=1, PCSource=01 in state 8. Op=000010 gives 0,1,11,0 with PCWrite=1, PCSource=10.
- Illegal opcode: Op=111111. Required: IllegalOp=1 for exactly the DECODE cycle, then State=0; no RegWrite or MemWrite asserted. Also run addi (Op=001000): 0,1,9,10,0 with ALUSrcB=10 in state 9.
